// File: rtl/mips.sv
// Board-level top of the timer experiment: 32-bit countdown timer with switch preset,
// key control, LED readout and scanned 7-segment display. Optional macro: UART_ECHO_EN.
module mips #(
   parameter int TICK_DIV = 20000000,
   parameter int SCAN_DIV = 10000
) (
   input  logic        clk_in,
   input  logic        sys_rstn,
   input  logic        uart_rxd,
   output logic        uart_txd,
   input  logic [7:0]  dip_switch0,
   input  logic [7:0]  dip_switch1,
   input  logic [7:0]  dip_switch2,
   input  logic [7:0]  dip_switch3,
   input  logic [7:0]  dip_switch4,
   input  logic [7:0]  dip_switch5,
   input  logic [7:0]  dip_switch6,
   input  logic [7:0]  dip_switch7,
   input  logic [7:0]  user_key,
   output logic [31:0] led_light,
   output logic [7:0]  digital_tube2,
   output logic        digital_tube_sel2,
   output logic [7:0]  digital_tube1,
   output logic [3:0]  digital_tube_sel1,
   output logic [7:0]  digital_tube0,
   output logic [3:0]  digital_tube_sel0
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [31:0] TICK_MAX = 32'(TICK_DIV - 1);
   localparam logic [31:0] SCAN_MAX = 32'(SCAN_DIV - 1);

   logic [31:0] count;
   logic [1:0]  state;
   logic [31:0] tick_cnt;
   logic [31:0] scan_cnt;
   logic [1:0]  idx;

   logic [31:0] preset;
   logic        mode;
   logic        key_load;
   logic        key_pause;

   assign preset    = {dip_switch3, dip_switch2, dip_switch1, dip_switch0};
   assign mode      = dip_switch4[0];
   assign key_load  = user_key[0];
   assign key_pause = user_key[1];

   // Timer core: reset > load > pause handling > tick.
   always_ff @(posedge clk_in) begin
      if (sys_rstn) begin
         count    <= '0;
         state    <= IDLE;
         tick_cnt <= '0;
      end else if (key_load) begin
         count    <= preset;
         state    <= RUN;
         tick_cnt <= '0;
      end else if (state == RUN && key_pause) begin
         state <= PAUSE;
      end else if (state == PAUSE && !key_pause) begin
         state <= RUN;
      end else if (state == RUN) begin
         if (tick_cnt == TICK_MAX) begin
            tick_cnt <= '0;
            if (count > 32'd1) begin
               count <= count - 32'd1;
            end else if (mode) begin
               count <= preset;
            end else begin
               count <= '0;
               state <= DONE;
            end
         end else begin
            tick_cnt <= tick_cnt + 32'd1;
         end
      end
   end

   // Digit scan runs regardless of timer state.
   always_ff @(posedge clk_in) begin
      if (sys_rstn) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == SCAN_MAX) begin
         scan_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 32'd1;
      end
   end

   function automatic logic [7:0] seg(input logic [3:0] v);
      case (v)
         4'h0: seg = 8'hC0;
         4'h1: seg = 8'hF9;
         4'h2: seg = 8'hA4;
         4'h3: seg = 8'hB0;
         4'h4: seg = 8'h99;
         4'h5: seg = 8'h92;
         4'h6: seg = 8'h82;
         4'h7: seg = 8'hF8;
         4'h8: seg = 8'h80;
         4'h9: seg = 8'h90;
         4'hA: seg = 8'h88;
         4'hB: seg = 8'h83;
         4'hC: seg = 8'hC6;
         4'hD: seg = 8'hA1;
         4'hE: seg = 8'h86;
         default: seg = 8'h8E;
      endcase
   endfunction

   logic [15:0] count_hi;
   logic [15:0] count_lo;
   logic [4:0]  bit_base;

   assign count_hi = count[31:16];
   assign count_lo = count[15:0];
   assign bit_base = {1'b0, idx, 2'b00};

   assign led_light         = count;
   assign digital_tube_sel0 = 4'b0001 << idx;
   assign digital_tube_sel1 = 4'b0001 << idx;
   assign digital_tube0     = seg(count_lo[bit_base[3:0] +: 4]);
   assign digital_tube1     = seg(count_hi[bit_base[3:0] +: 4]);
   assign digital_tube2     = seg({2'b00, state});
   assign digital_tube_sel2 = 1'b1;

`ifdef UART_ECHO_EN
   logic rx_q1;
   logic rx_q2;

   always_ff @(posedge clk_in) begin
      if (sys_rstn) begin
         rx_q1 <= 1'b1;
         rx_q2 <= 1'b1;
      end else begin
         rx_q1 <= uart_rxd;
         rx_q2 <= rx_q1;
      end
   end

   assign uart_txd = rx_q2;

   logic unused_inputs;
   assign unused_inputs = ^{dip_switch4[7:1], dip_switch5, dip_switch6, dip_switch7,
                            user_key[7:2], bit_base[4]};
`else
   assign uart_txd = 1'b1;

   logic unused_inputs;
   assign unused_inputs = ^{dip_switch4[7:1], dip_switch5, dip_switch6, dip_switch7,
                            user_key[7:2], bit_base[4], uart_rxd};
`endif

endmodule

// File: tb/tb_mips.sv
// Directed testbench for mips with TICK_DIV=4 and SCAN_DIV=2.
`timescale 1ns/1ps
module tb_mips;

   logic        clk_in = 1'b0;
   logic        sys_rstn = 1'b1;
   logic        uart_rxd = 1'b1;
   logic        uart_txd;
   logic [7:0]  dip_switch0 = '0, dip_switch1 = '0, dip_switch2 = '0, dip_switch3 = '0;
   logic [7:0]  dip_switch4 = '0, dip_switch5 = '0, dip_switch6 = '0, dip_switch7 = '0;
   logic [7:0]  user_key = '0;
   logic [31:0] led_light;
   logic [7:0]  digital_tube2;
   logic        digital_tube_sel2;
   logic [7:0]  digital_tube1;
   logic [3:0]  digital_tube_sel1;
   logic [7:0]  digital_tube0;
   logic [3:0]  digital_tube_sel0;

   int pass_cnt = 0;
   int check_cnt = 0;

   logic exp_q[$];

   mips #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
      .clk_in(clk_in), .sys_rstn(sys_rstn), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
      .dip_switch0(dip_switch0), .dip_switch1(dip_switch1), .dip_switch2(dip_switch2),
      .dip_switch3(dip_switch3), .dip_switch4(dip_switch4), .dip_switch5(dip_switch5),
      .dip_switch6(dip_switch6), .dip_switch7(dip_switch7), .user_key(user_key),
      .led_light(led_light), .digital_tube2(digital_tube2),
      .digital_tube_sel2(digital_tube_sel2), .digital_tube1(digital_tube1),
      .digital_tube_sel1(digital_tube_sel1), .digital_tube0(digital_tube0),
      .digital_tube_sel0(digital_tube_sel0)
   );

   // Clock / reset block
   always #5 clk_in = ~clk_in;

   // One rising edge, then settle so outputs are sampled and inputs driven off the edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_preset(input logic [31:0] p, input logic m);
      {dip_switch3, dip_switch2, dip_switch1, dip_switch0} = p;
      dip_switch4 = {7'h55, m};
      dip_switch5 = 8'hFF;
   endtask

   task automatic do_reset();
      sys_rstn = 1'b1;
      user_key = '0;
      repeat (3) step();
      sys_rstn = 1'b0;
   endtask

   task automatic load_pulse(input logic [31:0] p, input logic m);
      set_preset(p, m);
      user_key = 8'hFC | 8'h01;
      step();
      user_key = 8'hFC;
   endtask

   task automatic test_reset();
      sys_rstn = 1'b1;
      user_key = '0;
      repeat (3) step();
      check_cnt++;
      if (led_light !== 32'd0) $display("FAIL reset_led got=%h exp=%h", led_light, 32'd0);
      else pass_cnt++;
      check_cnt++;
      if (digital_tube0 !== 8'hC0 || digital_tube1 !== 8'hC0)
         $display("FAIL reset_tubes got=%h/%h exp=c0/c0", digital_tube0, digital_tube1);
      else pass_cnt++;
      check_cnt++;
      if (digital_tube_sel0 !== 4'b0001 || digital_tube_sel1 !== 4'b0001)
         $display("FAIL reset_sel got=%b/%b exp=0001/0001", digital_tube_sel0, digital_tube_sel1);
      else pass_cnt++;
      check_cnt++;
      if (digital_tube2 !== 8'hC0 || digital_tube_sel2 !== 1'b1)
         $display("FAIL reset_state_tube got=%h sel=%b exp=c0 sel=1", digital_tube2, digital_tube_sel2);
      else pass_cnt++;
      check_cnt++;
      if (uart_txd !== 1'b1) $display("FAIL reset_txd got=%b exp=1", uart_txd);
      else pass_cnt++;
      sys_rstn = 1'b0;
   endtask

   task automatic test_pause_idle();
      user_key = 8'h02;
      repeat (3) step();
      check_cnt++;
      if (digital_tube2 !== 8'hC0 || led_light !== 32'd0)
         $display("FAIL pause_idle got=%h led=%h exp=c0 led=0", digital_tube2, led_light);
      else pass_cnt++;
      user_key = '0;
   endtask

   task automatic test_countdown_mode0();
      logic [31:0] exp_c;
      logic [7:0]  exp_s;
      do_reset();
      load_pulse(32'd5, 1'b0);
      check_cnt++;
      if (led_light !== 32'd5 || digital_tube2 !== 8'hF9)
         $display("FAIL m0_load got=%h st=%h exp=5 st=f9", led_light, digital_tube2);
      else pass_cnt++;
      for (int n = 1; n <= 26; n++) begin
         step();
         exp_c = (n >= 20) ? 32'd0 : 32'(5 - n / 4);
         exp_s = (n >= 20) ? 8'hB0 : 8'hF9;
         check_cnt++;
         if (led_light !== exp_c || digital_tube2 !== exp_s)
            $display("FAIL m0_cycle%0d got=%h st=%h exp=%h st=%h", n, led_light, digital_tube2, exp_c, exp_s);
         else pass_cnt++;
      end
   endtask

   task automatic test_countdown_mode1();
      logic [31:0] exp_c;
      do_reset();
      load_pulse(32'd5, 1'b1);
      for (int n = 1; n <= 44; n++) begin
         step();
         exp_c = 32'(5 - ((n / 4) % 5));
         check_cnt++;
         if (led_light !== exp_c || digital_tube2 !== 8'hF9)
            $display("FAIL m1_cycle%0d got=%h st=%h exp=%h st=f9", n, led_light, digital_tube2, exp_c);
         else pass_cnt++;
      end
   endtask

   task automatic test_pause();
      do_reset();
      load_pulse(32'd10, 1'b0);
      repeat (6) step();
      check_cnt++;
      if (led_light !== 32'd9) $display("FAIL pause_pre got=%h exp=%h", led_light, 32'd9);
      else pass_cnt++;
      user_key = 8'h02;
      for (int n = 0; n < 10; n++) begin
         step();
         check_cnt++;
         if (led_light !== 32'd9 || digital_tube2 !== 8'hA4)
            $display("FAIL pause_hold%0d got=%h st=%h exp=9 st=a4", n, led_light, digital_tube2);
         else pass_cnt++;
      end
      user_key = '0;
      step();
      check_cnt++;
      if (led_light !== 32'd9 || digital_tube2 !== 8'hF9)
         $display("FAIL pause_resume got=%h st=%h exp=9 st=f9", led_light, digital_tube2);
      else pass_cnt++;
      step();
      check_cnt++;
      if (led_light !== 32'd9) $display("FAIL pause_res1 got=%h exp=%h", led_light, 32'd9);
      else pass_cnt++;
      step();
      check_cnt++;
      if (led_light !== 32'd8) $display("FAIL pause_res2 got=%h exp=%h", led_light, 32'd8);
      else pass_cnt++;
   endtask

   task automatic test_scan();
      logic [7:0] exp_t0 [4];
      logic [7:0] exp_t1 [4];
      logic [3:0] exp_sel;
      int         k_idx;
      exp_t0 = '{8'h8E, 8'h86, 8'hA1, 8'hC6};
      exp_t1 = '{8'h83, 8'h88, 8'h90, 8'h80};
      set_preset(32'h89AB_CDEF, 1'b0);
      user_key = 8'h01;
      sys_rstn = 1'b1;
      step();
      sys_rstn = 1'b0;
      // Holding load keeps the count fixed at the preset while the scan advances.
      for (int k = 0; k < 9; k++) begin
         step();
         k_idx = ((k + 1) / 2) % 4;
         exp_sel = 4'b0001 << k_idx;
         check_cnt++;
         if (led_light !== 32'h89AB_CDEF || digital_tube_sel0 !== exp_sel ||
             digital_tube_sel1 !== exp_sel || digital_tube0 !== exp_t0[k_idx] ||
             digital_tube1 !== exp_t1[k_idx])
            $display("FAIL scan%0d got led=%h sel=%b/%b t0=%h t1=%h exp led=89abcdef sel=%b t0=%h t1=%h",
                     k, led_light, digital_tube_sel0, digital_tube_sel1, digital_tube0,
                     digital_tube1, exp_sel, exp_t0[k_idx], exp_t1[k_idx]);
         else pass_cnt++;
      end
      user_key = '0;
   endtask

   task automatic test_uart();
      logic pat [6];
      logic exp_v;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      exp_q.delete();
`ifdef UART_ECHO_EN
      exp_q.push_back(1'b1);
`endif
      for (int i = 0; i < 6; i++) begin
         uart_rxd = pat[i];
`ifdef UART_ECHO_EN
         exp_q.push_back(pat[i]);
`else
         exp_q.push_back(1'b1);
`endif
         step();
         exp_v = exp_q.pop_front();
         check_cnt++;
         if (uart_txd !== exp_v) $display("FAIL uart%0d got=%b exp=%b", i, uart_txd, exp_v);
         else pass_cnt++;
      end
      uart_rxd = 1'b1;
   endtask

   initial begin
      test_reset();
      test_pause_idle();
      test_countdown_mode0();
      test_countdown_mode1();
      test_pause();
      test_scan();
      test_uart();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
